// File: rtl/seq_share_ctrl_if.sv
// seq_share_ctrl_if
// Bundles the requester handshake, the shared-circuit drive/response and the
// job status signals of seq_share_ctrl.
//   req0/req1, data0/data1 : job requests and job words (requester side)
//   gnt0/gnt1              : one-cycle accept pulses
//   seq_rst/seq_t/seq_x    : clear, enable and serial data to the shared circuit
//   seq_y                  : response of the shared circuit
//   busy/done/done_id      : job status and completion reporting
//   result                 : captured response of the last completed job
// master = requesters plus shared circuit; slave = the controller.
interface seq_share_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             seq_rst;
    logic             seq_t;
    logic             seq_x;
    logic             seq_y;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] result;

    modport master (
        output req0, req1, data0, data1, seq_y,
        input  gnt0, gnt1, seq_rst, seq_t, seq_x, busy, done, done_id, result
    );

    modport slave (
        input  req0, req1, data0, data1, seq_y,
        output gnt0, gnt1, seq_rst, seq_t, seq_x, busy, done, done_id, result
    );
endinterface

// File: rtl/seq_share_ctrl.sv
// seq_share_ctrl
// Shares one serial sequential circuit between two requesters. A granted job
// word is shifted LSB first into the circuit and its one-cycle-delayed y
// response is collected into a result word.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : seq_share_ctrl_if.slave (requests, grants, shared-circuit drive,
//          status and result)
//
// All outputs are registered, so the state register always describes the
// outputs being set up for the following cycle:
//   state   | meaning
//   IDLE    | arbitrate; a request produces gnt next cycle
//   CLR     | seq_rst pulse next cycle, bit counter cleared
//   SHIFT   | seq_t=1, seq_x=word[cnt] next cycle (WIDTH visits)
//   DRAIN   | quiet cycle next, last y response still arriving
//   DONE    | done pulse, result and done_id next cycle
module seq_share_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_share_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic             prio;      // 1: requester 1 wins a tie
    logic [WIDTH-1:0] word;
    logic             idx;
    logic [CW-1:0]    cnt;
    logic             t_d;       // seq_t one cycle late: seq_y now answers a shifted bit
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] cap_next;
    logic             pick1;

    always_comb begin
        cap_next = (cap >> 1) | (WIDTH'(bus.seq_y) << (WIDTH - 1));
        pick1    = bus.req1 && (!bus.req0 || prio);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            prio        <= 1'b0;
            word        <= '0;
            idx         <= 1'b0;
            cnt         <= '0;
            t_d         <= 1'b0;
            cap         <= '0;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.seq_rst <= 1'b0;
            bus.seq_t   <= 1'b0;
            bus.seq_x   <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.done_id <= 1'b0;
            bus.result  <= '0;
        end else begin
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.seq_rst <= 1'b0;
            bus.seq_t   <= 1'b0;
            bus.seq_x   <= 1'b0;
            bus.done    <= 1'b0;
            bus.busy    <= (state != S_IDLE);
            t_d         <= bus.seq_t;
            if (t_d) begin
                cap <= cap_next;
            end

            case (state)
                S_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        if (pick1) begin
                            bus.gnt1 <= 1'b1;
                            word     <= bus.data1;
                            idx      <= 1'b1;
                            prio     <= 1'b0;
                        end else begin
                            bus.gnt0 <= 1'b1;
                            word     <= bus.data0;
                            idx      <= 1'b0;
                            prio     <= 1'b1;
                        end
                        state <= S_CLR;
                    end
                end
                S_CLR: begin
                    bus.seq_rst <= 1'b1;
                    cnt         <= '0;
                    state       <= S_SHIFT;
                end
                S_SHIFT: begin
                    bus.seq_t <= 1'b1;
                    bus.seq_x <= word[cnt];
                    if (cnt == LAST_BIT) begin
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    // The response to the last bit arrives in this very cycle,
                    // so the result takes the capture including it.
                    bus.done    <= 1'b1;
                    bus.result  <= cap_next;
                    bus.done_id <= idx;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_share_ctrl.sv
module tb_seq_share_ctrl;
    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    seq_share_ctrl_if #(.WIDTH(8)) bus ();

    seq_share_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared circuit model: y follows x when t=1, cleared by seq_rst.
    always @(posedge clk) begin
        if (bus.seq_rst) bus.seq_y <= 1'b0;
        else if (bus.seq_t) bus.seq_y <= bus.seq_x;
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.seq_rst, bus.seq_t, bus.seq_x, bus.busy, bus.done, bus.done_id} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_flags got %b want 00000000",
                     {bus.gnt0, bus.gnt1, bus.seq_rst, bus.seq_t, bus.seq_x, bus.busy, bus.done, bus.done_id});
        end
        n_cmp++;
        if (bus.result !== 8'h00) begin
            n_err++;
            $display("FAIL reset_result got %h want 00", bus.result);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] w;
        exp_t e;
        w = 8'hA5;
        bus.data0 = w;
        bus.req0 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_cmp++;
                if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b100) begin
                    n_err++;
                    $display("FAIL single_gnt got gnt0/gnt1/busy=%b want 100", {bus.gnt0, bus.gnt1, bus.busy});
                end
                sb.push_back({1'b0, w});
                bus.req0 = 1'b0;
            end
            if (k == 1) begin
                n_cmp++;
                if ({bus.seq_rst, bus.seq_t, bus.seq_x, bus.busy} !== 4'b1001) begin
                    n_err++;
                    $display("FAIL single_clr got rst/t/x/busy=%b want 1001", {bus.seq_rst, bus.seq_t, bus.seq_x, bus.busy});
                end
            end
            if (k >= 2 && k <= 9) begin
                n_cmp++;
                if ({bus.seq_rst, bus.seq_t, bus.seq_x} !== {2'b01, w[k-2]}) begin
                    n_err++;
                    $display("FAIL single_shift%0d got rst/t/x=%b want 01%b", k - 2,
                             {bus.seq_rst, bus.seq_t, bus.seq_x}, w[k-2]);
                end
            end
            if (k == 10) begin
                n_cmp++;
                if ({bus.seq_rst, bus.seq_t, bus.seq_x, bus.done, bus.busy} !== 5'b00001) begin
                    n_err++;
                    $display("FAIL single_drain got rst/t/x/done/busy=%b want 00001",
                             {bus.seq_rst, bus.seq_t, bus.seq_x, bus.done, bus.busy});
                end
            end
            if (k == 11) begin
                n_cmp++;
                if ({bus.done, bus.busy} !== 2'b11) begin
                    n_err++;
                    $display("FAIL single_done got done/busy=%b want 11", {bus.done, bus.busy});
                end
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL single_sb got empty queue want one entry");
                end else begin
                    e = sb.pop_front();
                    if ({bus.done_id, bus.result} !== e) begin
                        n_err++;
                        $display("FAIL single_result got id=%b res=%h want id=%b res=%h",
                                 bus.done_id, bus.result, e.id, e.data);
                    end
                end
            end
            if (k == 12) begin
                n_cmp++;
                if ({bus.done, bus.busy} !== 2'b00) begin
                    n_err++;
                    $display("FAIL single_idle got done/busy=%b want 00", {bus.done, bus.busy});
                end
            end
            if (k == 15) begin
                n_cmp++;
                if ({bus.done_id, bus.result} !== {1'b0, w}) begin
                    n_err++;
                    $display("FAIL single_hold got id=%b res=%h want id=0 res=%h", bus.done_id, bus.result, w);
                end
            end
        end
    endtask

    task automatic test_rr_pair();
        int   g0_cyc;
        int   g1_cyc;
        int   dones;
        exp_t e;
        g0_cyc = -1;
        g1_cyc = -1;
        dones = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.data0 = 8'h3C;
        bus.data1 = 8'hC3;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n_cmp++;
            if ((bus.gnt0 & bus.gnt1) !== 1'b0) begin
                n_err++;
                $display("FAIL pair_exclusive cycle %0d got gnt0&gnt1=%b want 0", k, bus.gnt0 & bus.gnt1);
            end
            if (bus.gnt0 === 1'b1) begin
                if (g0_cyc < 0) g0_cyc = k;
                sb.push_back({1'b0, bus.data0});
                bus.req0 = 1'b0;
            end
            if (bus.gnt1 === 1'b1) begin
                if (g1_cyc < 0) g1_cyc = k;
                sb.push_back({1'b1, bus.data1});
                bus.req1 = 1'b0;
            end
            if (bus.done === 1'b1) begin
                dones++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL pair_sb got done with empty queue want entry");
                end else begin
                    e = sb.pop_front();
                    if ({bus.done_id, bus.result} !== e) begin
                        n_err++;
                        $display("FAIL pair_result got id=%b res=%h want id=%b res=%h",
                                 bus.done_id, bus.result, e.id, e.data);
                    end
                end
            end
        end
        n_cmp++;
        if (g0_cyc != 0) begin
            n_err++;
            $display("FAIL pair_gnt0_cycle got %0d want 0", g0_cyc);
        end
        n_cmp++;
        if (g1_cyc != 12) begin
            n_err++;
            $display("FAIL pair_gnt1_cycle got %0d want 12", g1_cyc);
        end
        n_cmp++;
        if (dones != 2) begin
            n_err++;
            $display("FAIL pair_done_count got %0d want 2", dones);
        end
    endtask

    task automatic test_back_to_back();
        int   grants;
        int   k;
        logic last;
        logic id;
        exp_t e;
        grants = 0;
        k = 0;
        last = 1'b1;
        bus.data0 = 8'($urandom);
        bus.data1 = 8'($urandom);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        while (!(grants >= 6 && sb.size() == 0) && k < 200) begin
            @(negedge clk);
            k++;
            if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
                id = bus.gnt1;
                n_cmp++;
                if (id === last) begin
                    n_err++;
                    $display("FAIL b2b_alternate grant %0d got id=%b want id=%b", grants, id, ~last);
                end
                sb.push_back({id, id ? bus.data1 : bus.data0});
                if (id) bus.data1 = 8'($urandom);
                else bus.data0 = 8'($urandom);
                last = id;
                grants++;
                if (grants == 6) begin
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end
            end
            if (bus.done === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_sb got done with empty queue want entry");
                end else begin
                    e = sb.pop_front();
                    if ({bus.done_id, bus.result} !== e) begin
                        n_err++;
                        $display("FAIL b2b_result got id=%b res=%h want id=%b res=%h",
                                 bus.done_id, bus.result, e.id, e.data);
                    end
                end
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        n_cmp++;
        if (grants != 6 || sb.size() != 0) begin
            n_err++;
            $display("FAIL b2b_complete got grants=%0d pending=%0d want grants=6 pending=0", grants, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_abort();
        int   gk;
        int   early_done;
        exp_t e;
        gk = -1;
        early_done = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.data0 = 8'h5A;
        bus.req0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_cmp++;
                if (bus.gnt0 !== 1'b1) begin
                    n_err++;
                    $display("FAIL abort_first_gnt got gnt0=%b want 1", bus.gnt0);
                end
                bus.req0 = 1'b0;
            end
            if (k == 6) begin
                n_cmp++;
                if (bus.seq_t !== 1'b1) begin
                    n_err++;
                    $display("FAIL abort_in_shift got seq_t=%b want 1", bus.seq_t);
                end
                rst = 1'b1;
            end
            if (k == 7) begin
                n_cmp++;
                if ({bus.seq_t, bus.busy, bus.done} !== 3'b000) begin
                    n_err++;
                    $display("FAIL abort_cleared got t/busy/done=%b want 000", {bus.seq_t, bus.busy, bus.done});
                end
                rst = 1'b0;
                bus.data0 = 8'h96;
                bus.data1 = 8'h69;
                bus.req0 = 1'b1;
                bus.req1 = 1'b1;
            end
        end
        for (int k = 8; k < 30; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1 && gk < 0) early_done++;
            if (gk < 0 && (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1)) begin
                gk = k;
                n_cmp++;
                if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
                    n_err++;
                    $display("FAIL abort_regrant got gnt0/gnt1=%b want 10", {bus.gnt0, bus.gnt1});
                end
                sb.push_back({bus.gnt1, bus.gnt1 ? bus.data1 : bus.data0});
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            if (bus.done === 1'b1 && gk >= 0) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL abort_sb got done with empty queue want entry");
                end else begin
                    e = sb.pop_front();
                    if ({bus.done_id, bus.result} !== e) begin
                        n_err++;
                        $display("FAIL abort_result got id=%b res=%h want id=%b res=%h",
                                 bus.done_id, bus.result, e.id, e.data);
                    end
                end
            end
        end
        n_cmp++;
        if (gk != 8 || early_done != 0) begin
            n_err++;
            $display("FAIL abort_sequence got grant_cycle=%0d early_done=%0d want 8 and 0", gk, early_done);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL abort_pending got %0d want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_rst_priority();
        exp_t e;
        int   got_done;
        got_done = 0;
        @(negedge clk);
        rst = 1'b1;
        bus.data0 = 8'h0F;
        bus.req0 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b000) begin
            n_err++;
            $display("FAIL rstprio_nognt got gnt0/gnt1/busy=%b want 000", {bus.gnt0, bus.gnt1, bus.busy});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt0 !== 1'b1) begin
            n_err++;
            $display("FAIL rstprio_gnt_after got gnt0=%b want 1", bus.gnt0);
        end
        sb.push_back({1'b0, bus.data0});
        bus.req0 = 1'b0;
        for (int k = 1; k < 20 && got_done == 0; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got_done = k;
                e = sb.pop_front();
                n_cmp++;
                if ({bus.done_id, bus.result} !== e) begin
                    n_err++;
                    $display("FAIL rstprio_result got id=%b res=%h want id=%b res=%h",
                             bus.done_id, bus.result, e.id, e.data);
                end
            end
        end
        n_cmp++;
        if (got_done != 11) begin
            n_err++;
            $display("FAIL rstprio_latency got done at %0d want 11", got_done);
        end
        sb.delete();
    endtask

    task automatic test_req_ignored();
        int   n_g1;
        int   g1_cyc;
        exp_t e;
        n_g1 = 0;
        g1_cyc = -1;
        bus.data0 = 8'hE1;
        bus.data1 = 8'h7E;
        bus.req0 = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (k == 0) begin
                sb.push_back({1'b0, bus.data0});
                bus.req0 = 1'b0;
            end
            if (k == 3) bus.req1 = 1'b1;
            if (k == 5) bus.req1 = 1'b0;
            if (k == 6) bus.req1 = 1'b1;
            if (k == 9) bus.req1 = 1'b0;
            if (bus.gnt1 === 1'b1) n_g1++;
            if (bus.done === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL ignore_sb got done with empty queue want entry");
                end else begin
                    e = sb.pop_front();
                    if ({bus.done_id, bus.result} !== e) begin
                        n_err++;
                        $display("FAIL ignore_result got id=%b res=%h want id=%b res=%h",
                                 bus.done_id, bus.result, e.id, e.data);
                    end
                end
            end
        end
        n_cmp++;
        if (n_g1 != 0) begin
            n_err++;
            $display("FAIL ignore_dropped got %0d gnt1 pulses want 0", n_g1);
        end
        bus.req0 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) bus.req0 = 1'b0;
            if (k == 4) bus.req1 = 1'b1;
            if (bus.gnt1 === 1'b1 && g1_cyc < 0) begin
                g1_cyc = k;
                bus.req1 = 1'b0;
            end
        end
        bus.req1 = 1'b0;
        n_cmp++;
        if (g1_cyc != 12) begin
            n_err++;
            $display("FAIL ignore_held got gnt1 at %0d want 12", g1_cyc);
        end
        sb.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.data0 = 8'h00;
        bus.data1 = 8'h00;
        test_reset();
        test_single();
        test_rr_pair();
        test_back_to_back();
        test_abort();
        test_rst_priority();
        test_req_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_share_ctrl.md
SEQ_SHARE_CTRL -- requirements
Module: seq_share_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of bits serialized per job into the shared sequential circuit.
REQ-002 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0, req1  input  1 each  job request from requester 0/1, level, held until granted.
REQ-005 SHALL have ports data0, data1  input  WIDTH each  job word of requester 0/1, sampled in the grant cycle.
REQ-006 SHALL have ports gnt0, gnt1  output  1 each  one-cycle accept pulse to requester 0/1.
REQ-007 SHALL have port seq_rst  output  1  clear pulse to the shared sequential circuit.
REQ-008 SHALL have port seq_t  output  1  enable (t) to the shared circuit.
REQ-009 SHALL have port seq_x  output  1  serial data (x) to the shared circuit.
REQ-010 SHALL have port seq_y  input  1  output (y) of the shared circuit.
REQ-011 SHALL have ports busy, done, done_id  output  1 each  job in progress; one-cycle completion pulse; requester index of the completed job.
REQ-012 SHALL have port result  output  WIDTH  captured y response of the last completed job.

Function
REQ-013 SHALL implement FSM IDLE -> CLR -> SHIFT (WIDTH cycles) -> DRAIN -> DONE -> IDLE, one state per cycle except SHIFT.
REQ-014 In IDLE with any req asserted, SHALL assert exactly one gnt for that cycle, latch its data word and index, and move to CLR.
REQ-015 Arbitration SHALL be round-robin: both req asserted -> grant the requester not granted last; single req -> grant it; pointer after reset favours req0.
REQ-016 Requests SHALL be ignored (no gnt) in every state other than IDLE; a req dropped before grant SHALL be forgotten without side effect.
REQ-017 CLR SHALL drive seq_rst=1, seq_t=0, seq_x=0 for exactly one cycle.
REQ-018 SHIFT cycle i (i=0..WIDTH-1) SHALL drive seq_t=1 and seq_x=latched_word[i] (LSB first).
REQ-019 y response to the bit driven in SHIFT cycle i SHALL be captured from seq_y at the end of the following cycle (SHIFT i+1, or DRAIN for i=WIDTH-1) into capture bit i.
REQ-020 DRAIN SHALL drive seq_t=0, seq_x=0; seq_rst SHALL be 0 outside CLR; seq_t and seq_x SHALL be 0 outside SHIFT.
REQ-021 DONE SHALL pulse done=1 for one cycle with result=capture register and done_id=latched index; result and done_id SHALL hold until the next DONE.
REQ-022 Latency SHALL be fixed: grant in cycle 0 -> done in cycle WIDTH+3; next grant no earlier than cycle WIDTH+4.
REQ-023 busy SHALL be 1 in CLR, SHIFT, DRAIN, DONE and 0 in IDLE.
REQ-024 Bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap into an extra SHIFT cycle.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, round-robin pointer to favour req0, and gnt0/gnt1/seq_rst/seq_t/seq_x/busy/done/done_id=0, result=0, from the next cycle.
REQ-026 rst during any active state SHALL abort the job with no done pulse; the aborted requester SHALL re-request.
REQ-027 rst SHALL take priority over a simultaneous req in IDLE (no gnt that cycle).

Verification (bench models shared circuit as y = x registered when t=1, cleared by seq_rst, so result==data)
REQ-028 rst held 2 cycles -> all outputs 0, busy=0, result=8'h00.
REQ-029 req0=1, data0=8'hA5 -> gnt0 in cycle 0, seq_rst cycle 1, seq_x=1,0,1,0,0,1,0,1 cycles 2-9, done cycle 11, result=8'hA5, done_id=0.
REQ-030 req0=req1=1 from reset, data0=8'h3C, data1=8'hC3 -> gnt0 first (done_id=0, 8'h3C), gnt1 in cycle 12 (done_id=1, 8'hC3).
REQ-031 req0 and req1 held permanently -> grants alternate 0,1,0,1; never two consecutive grants to the same requester.
REQ-032 rst asserted in SHIFT cycle 4 of a job -> seq_t=0 and busy=0 next cycle, no done, next job with both req granted to requester 0.
REQ-033 req1 toggled during SHIFT -> no gnt1 until IDLE; req1 dropped before IDLE -> no grant.
